// File: rtl/lsu_ram.sv
// Load/store unit with a byte-banked word RAM: decodes RV32I LOAD/STORE requests,
// reads/writes the RAM at the accepting edge and returns in-order tagged responses.
module lsu_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int TAG_WIDTH  = 4,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_fault
);
    localparam int WORDS = 1 << (ADDR_WIDTH - 2);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OW    = $clog2(FIFO_DEPTH + 1);
    localparam int L     = LATENCY - 1;

    logic [31:0]           r_mem [0:WORDS-1];

    logic [31:0]           r_raw   [0:LATENCY-1];
    logic                  r_pv    [0:LATENCY-1];
    logic                  r_pwe   [0:LATENCY-1];
    logic                  r_pfault[0:LATENCY-1];
    logic [1:0]            r_plo   [0:LATENCY-1];
    logic [2:0]            r_pf3   [0:LATENCY-1];
    logic [TAG_WIDTH-1:0]  r_ptag  [0:LATENCY-1];

    logic [31:0]           r_q_rdata[0:FIFO_DEPTH-1];
    logic [TAG_WIDTH-1:0]  r_q_tag  [0:FIFO_DEPTH-1];
    logic                  r_q_fault[0:FIFO_DEPTH-1];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [OW-1:0]         r_qcnt;
    logic [OW-1:0]         r_occ;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_size;
    logic                  w_f3_bad;
    logic                  w_mis;
    logic                  w_oor;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [31:0]           w_shift;
    logic [31:0]           w_ld;
    logic [31:0]           w_push_rdata;

    assign req_ready = (r_occ < OW'(FIFO_DEPTH)) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_qcnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_pv[L];
    assign w_idx     = req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        w_size   = req_funct3[1:0];
        w_f3_bad = req_we ? (req_funct3[2] || (w_size == 2'b11))
                          : ((w_size == 2'b11) || (req_funct3[2] && (w_size == 2'b10)));
        w_mis    = ((w_size == 2'b01) && req_addr[0]) ||
                   ((w_size == 2'b10) && (req_addr[1:0] != 2'b00));
        w_oor    = ((req_addr >> ADDR_WIDTH) != 32'd0);
        w_fault  = w_f3_bad || w_mis || w_oor;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // RAM and raw read data carry no reset; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (w_accept) r_raw[0] <= r_mem[w_idx];
        for (int k = 1; k < LATENCY; k++) r_raw[k] <= r_raw[k-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_pv[k]     <= 1'b0;
                r_pwe[k]    <= 1'b0;
                r_pfault[k] <= 1'b0;
                r_plo[k]    <= 2'b00;
                r_pf3[k]    <= 3'b000;
                r_ptag[k]   <= '0;
            end
        end else begin
            r_pv[0]     <= w_accept;
            r_pwe[0]    <= req_we;
            r_pfault[0] <= w_fault;
            r_plo[0]    <= req_addr[1:0];
            r_pf3[0]    <= req_funct3;
            r_ptag[0]   <= req_tag;
            for (int k = 1; k < LATENCY; k++) begin
                r_pv[k]     <= r_pv[k-1];
                r_pwe[k]    <= r_pwe[k-1];
                r_pfault[k] <= r_pfault[k-1];
                r_plo[k]    <= r_plo[k-1];
                r_pf3[k]    <= r_pf3[k-1];
                r_ptag[k]   <= r_ptag[k-1];
            end
        end
    end

    always_comb begin
        w_shift = r_raw[L] >> {r_plo[L], 3'b000};
        case (r_pf3[L][1:0])
            2'b00:   w_ld = {{24{~r_pf3[L][2] & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ld = {{16{~r_pf3[L][2] & w_shift[15]}}, w_shift[15:0]};
            default: w_ld = w_shift;
        endcase
        w_push_rdata = (r_pwe[L] || r_pfault[L]) ? 32'd0 : w_ld;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rdata[r_wptr] <= w_push_rdata;
            r_q_tag[r_wptr]   <= r_ptag[L];
            r_q_fault[r_wptr] <= r_pfault[L];
        end
    end

    // The occupancy counter reserves a queue slot at accept, so a push never overflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_qcnt <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_qcnt <= r_qcnt + OW'(1);
                2'b01:   r_qcnt <= r_qcnt - OW'(1);
                default: r_qcnt <= r_qcnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign rsp_rdata = rsp_valid ? r_q_rdata[r_rptr] : 32'd0;
    assign rsp_tag   = rsp_valid ? r_q_tag[r_rptr]   : '0;
    assign rsp_fault = rsp_valid ? r_q_fault[r_rptr] : 1'b0;

endmodule
